mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the LC-3 CPU's MAR/MDR memory interface.
- Accepts word read and write requests from the CPU control path and holds a word-addressed on-chip RAM.
- Inserts a programmable number of wait states, then returns read data on DATA_TO_CPU with a one-cycle MEM_READY strobe.
- Decodes the top address as memory-mapped I/O: switch input on read, hex display register on write.

Parameters:
- DEPTH, 256: number of 16-bit RAM words; addresses 0..DEPTH-1 map to RAM.
- WAIT_STATES, 2: number of wait cycles inserted before each access; legal range 0..15.
- IO_ADDR, 16'hFFFF: address decoded as the I/O port.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- MEM_CE  input  1  access request from the CPU; held high until MEM_READY is seen.
- MEM_WE  input  1  1 = write, 0 = read; sampled with the request.
- ADDR  input  16  word address (CPU MAR).
- DATA_IN  input  16  write data (CPU MDR).
- SWITCHES  input  16  board switch value returned on a read of IO_ADDR.
- DATA_TO_CPU  output  16  registered read data for the CPU MDR mux.
- MEM_READY  output  1  one-cycle completion strobe.
- BUSY  output  1  high in every state except IDLE.
- HEX_OUT  output  16  I/O display register.

Behaviour:
- Reset (Reset=0, asynchronous):
  - FSM goes to IDLE.
  - DATA_TO_CPU=0, MEM_READY=0, BUSY=0, HEX_OUT=0, wait counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
- IDLE:
  - On an edge with MEM_CE=1, latch ADDR, DATA_IN and MEM_WE into internal registers.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else to ACCESS.
- WAIT:
  - Decrement the counter each cycle; go to ACCESS on the edge where the counter is 1.
  - If MEM_CE=0 on any WAIT edge, abort to IDLE: no write, no MEM_READY, DATA_TO_CPU unchanged.
- ACCESS (exactly one cycle; uses latched values only):
  - Write to RAM, addr<DEPTH: RAM[addr]<=data.
  - Write to IO_ADDR: HEX_OUT<=data.
  - Write to any other address: discarded.
  - Read from RAM, addr<DEPTH: DATA_TO_CPU<=RAM[addr].
  - Read from IO_ADDR: DATA_TO_CPU<=SWITCHES, sampled at the ACCESS edge.
  - Read from any other address: DATA_TO_CPU<=0.
  - Writes leave DATA_TO_CPU unchanged.
  - Go to DONE.
- DONE:
  - MEM_READY=1 for exactly this one cycle.
  - Go to HOLD if MEM_CE=1, else to IDLE.
- HOLD:
  - Wait until MEM_CE=0, then go to IDLE.
  - Guarantees one access per request; a held MEM_CE never causes a repeated write.
- Latency: with MEM_CE first high in IDLE during cycle 0, MEM_READY is high in cycle WAIT_STATES+2 and DATA_TO_CPU is valid in that same cycle.
- Changes to ADDR, DATA_IN or MEM_WE after the request edge are ignored.
- BUSY=1 in WAIT, ACCESS, DONE and HOLD.
- Reset asserted mid-operation:
  - A write whose ACCESS edge has not yet occurred is never performed.
  - Any pending MEM_READY is lost.
- MEM_CE=0 in DONE: go to IDLE directly; a new request is accepted on the next edge.
- RAM is a single-port synchronous array, inferable as block RAM. Read data is registered once into DATA_TO_CPU; no combinational path from ADDR to DATA_TO_CPU.

Test Plan:
- Reset=0 pulse mid-cycle, async → all outputs 0 immediately; after release, write 16'h1234 to addr 5, then read addr 5 → DATA_TO_CPU=16'h1234 with MEM_READY in cycle 4 (WAIT_STATES=2).
- WAIT_STATES=0: read addr 0 after writing 16'hBEEF → MEM_READY in cycle 2, exactly one cycle wide.
- Write 16'h00A5 to 16'hFFFF → HEX_OUT=16'h00A5. With SWITCHES=16'h0F0F, read 16'hFFFF → DATA_TO_CPU=16'h0F0F.
- Hold MEM_CE=1 with MEM_WE=1 for 10 cycles, writing addr 3 → exactly one MEM_READY pulse, FSM stays in HOLD, BUSY=1 until MEM_CE=0.
- Drop MEM_CE in cycle 1 of a write to addr 7 (previous value 16'h1111) → no MEM_READY, FSM returns to IDLE, RAM[7] stays 16'h1111.
- Read addr DEPTH (256) → DATA_TO_CPU=0. Write 16'hFFFF to addr 300 → no RAM word changes. Assert Reset during WAIT of a write to addr 9 → RAM[9] unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM plus one memory-mapped I/O port behind the LC-3 MAR/MDR interface.
// Each request passes through a programmable wait-state delay before its single access.
module mem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_CE,
  input  logic        MEM_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] DATA_TO_CPU,
  output logic        MEM_READY,
  output logic        BUSY,
  output logic [15:0] HEX_OUT,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: the CPU raises MEM_CE with ADDR/DATA_IN/MEM_WE valid and keeps it high
  // until MEM_READY (one cycle) is seen; the request is captured on the first edge only.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;

  logic [15:0] ram [DEPTH];
  logic        in_ram;
  logic        is_io;
  logic        ram_we;

  assign in_ram = ({1'b0, addr_q} < 17'(DEPTH));
  assign is_io  = (addr_q == IO_ADDR);
  assign ram_we = (state_q == S_ACCESS) && we_q && in_ram;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        if (MEM_CE) begin
          addr_d  = ADDR;
          wdata_d = DATA_IN;
          we_d    = MEM_WE;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES != 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        // A dropped request abandons the access before anything is written.
        if (!MEM_CE) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          if (!in_ram && is_io) hex_d = wdata_q;
        end else if (in_ram) begin
          rdata_d = ram[addr_q[AW-1:0]];
        end else if (is_io) begin
          rdata_d = SWITCHES;
        end else begin
          rdata_d = 16'h0000;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = MEM_CE ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!MEM_CE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  // RAM has no reset so its contents survive Reset and it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (ram_we) ram[addr_q[AW-1:0]] <= wdata_q;
  end

  assign DATA_TO_CPU = rdata_q;
  assign HEX_OUT     = hex_q;
  assign MEM_READY   = (state_q == S_DONE);
  assign BUSY        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for single accesses plus
// hand sequences for reset, held request, abort and the zero-wait-state instance.
module tb_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        MEM_CE, MEM_CE0;
  logic        MEM_WE;
  logic [15:0] ADDR, DATA_IN, SWITCHES;
  logic [15:0] DATA_TO_CPU, DATA_TO_CPU0;
  logic        MEM_READY, MEM_READY0;
  logic        BUSY, BUSY0;
  logic [15:0] HEX_OUT, HEX_OUT0;
  logic [2:0]  dbg_state, dbg_state0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd;

  mem_responder #(.DEPTH(256), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .SWITCHES(SWITCHES), .DATA_TO_CPU(DATA_TO_CPU),
    .MEM_READY(MEM_READY), .BUSY(BUSY), .HEX_OUT(HEX_OUT), .dbg_state_o(dbg_state)
  );

  mem_responder #(.DEPTH(256), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(Clk), .Reset(Reset), .MEM_CE(MEM_CE0), .MEM_WE(MEM_WE), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .SWITCHES(SWITCHES), .DATA_TO_CPU(DATA_TO_CPU0),
    .MEM_READY(MEM_READY0), .BUSY(BUSY0), .HEX_OUT(HEX_OUT0), .dbg_state_o(dbg_state0)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // driver: one complete request; sel=1 targets the zero-wait instance
  task automatic do_access(input bit sel, input logic we, input logic [15:0] addr,
                           input logic [15:0] data, input int exp_lat,
                           output logic [15:0] rd_at_ready);
    bit got;
    int lat;
    logic rdy;
    got = 1'b0;
    lat = -1;
    rd_at_ready = 16'h0000;
    @(posedge Clk); #1;
    ADDR = addr; DATA_IN = data; MEM_WE = we;
    if (sel) MEM_CE0 = 1'b1; else MEM_CE = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge Clk);
      rdy = sel ? MEM_READY0 : MEM_READY;
      if (rdy) begin
        got = 1'b1;
        lat = c;
        rd_at_ready = sel ? DATA_TO_CPU0 : DATA_TO_CPU;
      end else if (c == 1) begin
        ADDR = 16'($urandom);
        DATA_IN = 16'($urandom);
        MEM_WE = ~MEM_WE;
      end
    end
    check("ready_seen", {31'd0, got}, 32'd1);
    check("ready_latency", 32'(lat), 32'(exp_lat));
    @(negedge Clk);
    check("ready_width", {31'd0, sel ? MEM_READY0 : MEM_READY}, 32'd0);
    check("busy_hold", {31'd0, sel ? BUSY0 : BUSY}, 32'd1);
    @(posedge Clk); #1;
    if (sel) MEM_CE0 = 1'b0; else MEM_CE = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("busy_idle", {31'd0, sel ? BUSY0 : BUSY}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sw;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] rd;
    int pulses;

    Reset = 1'b0; MEM_CE = 1'b0; MEM_CE0 = 1'b0; MEM_WE = 1'b0;
    ADDR = 16'h0000; DATA_IN = 16'h0000; SWITCHES = 16'h0000;
    last_rd = 16'h0000;

    vecs[0]  = '{1'b1, 16'd5,    16'h1234, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'd5,    16'h0000, 16'h0000, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b1, 16'd44,   16'h5A5A, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 16'd300,  16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 16'd44,   16'h0000, 16'h0000, 16'h5A5A, 16'h0000};
    vecs[5]  = '{1'b0, 16'd256,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, 16'h00A5};
    vecs[7]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h00A5};
    vecs[8]  = '{1'b0, 16'd5,    16'h0000, 16'h0F0F, 16'h1234, 16'h00A5};
    vecs[9]  = '{1'b1, 16'd10,   16'hCAFE, 16'h0000, 16'h0000, 16'h00A5};
    vecs[10] = '{1'b0, 16'd10,   16'h0000, 16'h0000, 16'hCAFE, 16'h00A5};

    #12;
    check("rst_data", {16'd0, DATA_TO_CPU}, 32'd0);
    check("rst_ready", {31'd0, MEM_READY}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_hex", {16'd0, HEX_OUT}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      SWITCHES = vecs[i].sw;
      if (!vecs[i].we) exp_q.push_back(vecs[i].exp_rd);
      do_access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data, 4, rd);
      if (!vecs[i].we) begin
        last_rd = exp_q.pop_front();
        check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, last_rd});
      end else begin
        check($sformatf("vec%0d_data_kept", i), {16'd0, DATA_TO_CPU}, {16'd0, last_rd});
      end
      check($sformatf("vec%0d_hex", i), {16'd0, HEX_OUT}, {16'd0, vecs[i].exp_hex});
    end

    // async reset during WAIT of a write: the write must not land
    do_access(1'b0, 1'b1, 16'd9, 16'h9999, 4, rd);
    @(posedge Clk); #1;
    ADDR = 16'd9; DATA_IN = 16'h0000; MEM_WE = 1'b1; MEM_CE = 1'b1;
    @(posedge Clk); #3;
    Reset = 1'b0;
    #1;
    check("midrst_data", {16'd0, DATA_TO_CPU}, 32'd0);
    check("midrst_hex", {16'd0, HEX_OUT}, 32'd0);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_ready", {31'd0, MEM_READY}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    MEM_CE = 1'b0;
    #10 Reset = 1'b1;
    last_rd = 16'h0000;
    do_access(1'b0, 1'b0, 16'd9, 16'h0000, 4, rd);
    check("midrst_ram9", {16'd0, rd}, 32'h9999);

    // MEM_CE held with a write for 10 cycles: one access, parked in HOLD
    @(posedge Clk); #1;
    ADDR = 16'd3; DATA_IN = 16'h3333; MEM_WE = 1'b1; MEM_CE = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (MEM_READY) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_state", {29'd0, dbg_state}, 32'd4);
    check("hold_busy", {31'd0, BUSY}, 32'd1);
    @(posedge Clk); #1;
    MEM_CE = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("hold_release_busy", {31'd0, BUSY}, 32'd0);
    do_access(1'b0, 1'b0, 16'd3, 16'h0000, 4, rd);
    check("hold_ram3", {16'd0, rd}, 32'h3333);
    last_rd = rd;

    // request dropped in its first WAIT cycle
    do_access(1'b0, 1'b1, 16'd7, 16'h1111, 4, rd);
    @(posedge Clk); #1;
    ADDR = 16'd7; DATA_IN = 16'h2222; MEM_WE = 1'b1; MEM_CE = 1'b1;
    @(posedge Clk); #1;
    MEM_CE = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (MEM_READY) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    check("abort_data_kept", {16'd0, DATA_TO_CPU}, {16'd0, last_rd});
    do_access(1'b0, 1'b0, 16'd7, 16'h0000, 4, rd);
    check("abort_ram7", {16'd0, rd}, 32'h1111);

    // zero wait states
    do_access(1'b1, 1'b1, 16'd0, 16'hBEEF, 2, rd);
    exp_q.push_back(16'hBEEF);
    do_access(1'b1, 1'b0, 16'd0, 16'h0000, 2, rd);
    check("ws0_rdata", {16'd0, rd}, {16'd0, exp_q.pop_front()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
